// File: rtl/base_alu_pkg.sv
// Purpose : shared op/base codes, FSM encoding and cost model for base_alu_responder.
// Latency : n/a (constants and a pure function only).
// Backpr. : n/a.
// Contents: OP_* op codes, BASE_* base codes, ST_* state encoding, op_legal(), op_cost().
package base_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;

  localparam logic [1:0] BASE_2  = 2'd0;
  localparam logic [1:0] BASE_10 = 2'd1;
  localparam logic [1:0] BASE_12 = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_SHR;
  endfunction

  // Each base has three "native" ops that run fast; everything else is slow.
  // Illegal requests are rejected quickly, so they are charged the fast cost.
  function automatic logic [3:0] op_cost(input logic [3:0] op, input logic [1:0] base,
                                         input logic [3:0] fast, input logic [3:0] slow);
    logic native;
    native = 1'b0;
    if (!op_legal(op) || base == 2'd3) begin
      native = 1'b1;
    end else begin
      case (base)
        BASE_2:  native = (op <= OP_MUL);
        BASE_10: native = (op >= OP_DIV) && (op <= OP_OR);
        BASE_12: native = (op >= OP_XOR);
        default: native = 1'b1;
      endcase
    end
    return native ? fast : slow;
  endfunction

endpackage

// File: rtl/base_alu_datapath.sv
// Purpose : combinational ALU result and error flag for one latched request.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the caller decides when to sample.
// Ports   : op_i/a_i/b_i operands, base_ok_i base validity -> result_o, err_o.
module base_alu_datapath
  import base_alu_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter logic [WIDTH-1:0] DIV_ZERO_VALUE = '1
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             base_ok_i,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    if (!base_ok_i) begin
      err_o = 1'b1;
    end else begin
      case (op_i)
        OP_ADD: result_o = a_i + b_i;
        OP_SUB: result_o = a_i - b_i;
        OP_MUL: result_o = a_i * b_i;
        OP_DIV: begin
          if (b_i == '0) begin
            result_o = DIV_ZERO_VALUE;
            err_o    = 1'b1;
          end else begin
            result_o = a_i / b_i;
          end
        end
        OP_AND: result_o = a_i & b_i;
        OP_OR:  result_o = a_i | b_i;
        OP_XOR: result_o = a_i ^ b_i;
        OP_SHL: result_o = a_i << shamt;
        OP_SHR: result_o = a_i >> shamt;
        default: err_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/base_alu_responder.sv
// Purpose : single-request ALU responder with base-dependent cost model and run counters.
// Latency : accept on edge k -> done high in the cycle after edge k+cost+1.
// Backpr. : req_ready only in IDLE; req_valid outside IDLE is dropped, never queued.
// Ports   : req_valid/req_ready handshake, operation/operand_a/operand_b/base_select in,
//           result/done/err out, busy_cycles (saturating) and ops_completed (wrapping).
module base_alu_responder
  import base_alu_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter int               FAST_CYCLES    = 1,
  parameter int               SLOW_CYCLES    = 3,
  parameter logic [WIDTH-1:0] DIV_ZERO_VALUE = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [1:0]       base_select,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             err,
  output logic [31:0]      busy_cycles,
  output logic [15:0]      ops_completed
);

  localparam logic [3:0] FAST_C = 4'(FAST_CYCLES);
  localparam logic [3:0] SLOW_C = 4'(SLOW_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       base_q, base_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_flag_q, err_flag_d;  // error held from EXEC until the done pulse
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [31:0]      busy_q, busy_d;
  logic [15:0]      ops_q, ops_d;

  logic [WIDTH-1:0] dp_result;
  logic             dp_err;

  base_alu_datapath #(
    .WIDTH          (WIDTH),
    .DIV_ZERO_VALUE (DIV_ZERO_VALUE)
  ) u_datapath (
    .op_i      (op_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .base_ok_i (base_q != 2'd3),
    .result_o  (dp_result),
    .err_o     (dp_err)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    base_d     = base_q;
    result_d   = result_q;
    err_flag_d = err_flag_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    busy_d     = busy_q;
    ops_d      = ops_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = operation;
          a_d     = operand_a;
          b_d     = operand_b;
          base_d  = base_select;
          cnt_d   = op_cost(operation, base_select, FAST_C, SLOW_C) - 4'd1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (busy_q != '1) busy_d = busy_q + 32'd1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d   = dp_result;
          err_flag_d = dp_err;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        // done/err are registered on leaving DONE, so the pulse lands in the
        // first IDLE cycle alongside the updated completion count.
        done_d  = 1'b1;
        err_d   = err_flag_q;
        ops_d   = ops_q + 16'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      base_q     <= '0;
      result_q   <= '0;
      err_flag_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= '0;
      ops_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      base_q     <= base_d;
      result_q   <= result_d;
      err_flag_q <= err_flag_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      ops_q      <= ops_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign result        = result_q;
  assign done          = done_q;
  assign err           = err_q;
  assign busy_cycles   = busy_q;
  assign ops_completed = ops_q;

endmodule

// File: tb/tb_base_alu_responder.sv
// Purpose : directed self-checking bench for base_alu_responder.
// Latency : checks done arrives cost+1 edges after the accept edge.
// Backpr. : checks req_ready drops after accept and held req_valid is not queued.
module tb_base_alu_responder;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  operation;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [1:0]  base_select;
  logic [31:0] result;
  logic        done;
  logic        err;
  logic [31:0] busy_cycles;
  logic [15:0] ops_completed;

  int errors = 0;
  int checks = 0;
  int exp_busy = 0;
  int exp_ops = 0;

  base_alu_responder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .operation     (operation),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .base_select   (base_select),
    .result        (result),
    .done          (done),
    .err           (err),
    .busy_cycles   (busy_cycles),
    .ops_completed (ops_completed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] base,
                       input logic [31:0] exp_res, input logic exp_err,
                       input int cost, input bit hold);
    int n;
    bit seen;
    int extra;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    operation   = op;
    operand_a   = a;
    operand_b   = b;
    base_select = base;
    req_valid   = 1'b1;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    // Scramble inputs: the latched request must not see them.
    operation   = op ^ 4'h5;
    operand_a   = ~a;
    operand_b   = ~b;
    base_select = ~base;
    check({tag, "_busy_rdy"}, 32'(req_ready), 32'd0);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (done) seen = 1'b1;
    end
    req_valid = 1'b0;
    exp_busy += cost;
    exp_ops++;
    check({tag, "_seen"},    32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(cost + 1));
    check({tag, "_result"},  result, exp_res);
    check({tag, "_err"},     32'(err), 32'(exp_err));
    check({tag, "_ops"},     32'(ops_completed), 32'(exp_ops));
    check({tag, "_busy"},    busy_cycles, 32'(exp_busy));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_err_pulse"},  32'(err), 32'd0);
    check({tag, "_res_hold"},   result, exp_res);
    if (hold) begin
      extra = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      check({tag, "_no_extra_done"}, 32'(extra), 32'd0);
      check({tag, "_ops_after"}, 32'(ops_completed), 32'(exp_ops));
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    operation   = 4'd0;
    operand_a   = 32'd0;
    operand_b   = 32'd0;
    base_select = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result, 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_err",    32'(err), 32'd0);
    check("rst_busy",   busy_cycles, 32'd0);
    check("rst_ops",    32'(ops_completed), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(req_ready), 32'd1);

    // op, a, b, base, expected result, expected err, cost, hold
    do_op("add_b2",   4'd0, 32'h1234, 32'h5678, 2'd0, 32'h0000_68AC, 1'b0, 1, 1'b0);
    do_op("div_b10",  4'd3, 32'd100,  32'd10,   2'd1, 32'd10,        1'b0, 1, 1'b0);
    do_op("div_b2",   4'd3, 32'd100,  32'd10,   2'd0, 32'd10,        1'b0, 3, 1'b0);
    do_op("mul_b12",  4'd2, 32'hFF,   32'hAA,   2'd2, 32'h0000_A956, 1'b0, 3, 1'b0);
    do_op("shr_b12",  4'd8, 32'd144,  32'd4,    2'd2, 32'd9,         1'b0, 1, 1'b0);
    do_op("xor_b12",  4'd6, 32'd12,   32'd6,    2'd2, 32'd10,        1'b0, 1, 1'b0);
    do_op("sub_wrap", 4'd1, 32'd3,    32'd5,    2'd0, 32'hFFFF_FFFE, 1'b0, 1, 1'b0);
    do_op("shl_b2",   4'd7, 32'd1,    32'd35,   2'd0, 32'd8,         1'b0, 3, 1'b0);
    do_op("and_b10",  4'd4, 32'hF0F0, 32'h0FF0, 2'd1, 32'h0000_00F0, 1'b0, 1, 1'b0);
    do_op("or_b12",   4'd5, 32'hF000, 32'h000F, 2'd2, 32'h0000_F00F, 1'b0, 3, 1'b0);
    do_op("div_zero", 4'd3, 32'd5,    32'd0,    2'd1, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
    do_op("ill_op",   4'd9, 32'd7,    32'd8,    2'd0, 32'd0,         1'b1, 1, 1'b0);
    do_op("ill_base", 4'd0, 32'd7,    32'd8,    2'd3, 32'd0,         1'b1, 1, 1'b0);
    do_op("hold_sub", 4'd1, 32'd10,   32'd3,    2'd1, 32'd7,         1'b0, 3, 1'b1);

    // Reset in the middle of a slow op aborts it and clears everything.
    operation   = 4'd0;
    operand_a   = 32'd1;
    operand_b   = 32'd2;
    base_select = 2'd1;
    req_valid   = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_accepted", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("abort_result", result, 32'd0);
    check("abort_done",   32'(done), 32'd0);
    check("abort_err",    32'(err), 32'd0);
    check("abort_busy",   busy_cycles, 32'd0);
    check("abort_ops",    32'(ops_completed), 32'd0);
    begin
      int dones;
      dones = 0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        if (done) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);
    end
    @(negedge clk);
    reset_n  = 1'b1;
    exp_busy = 0;
    exp_ops  = 0;
    do_op("post_rst_add", 4'd0, 32'd40, 32'd2, 2'd0, 32'd42, 1'b0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/base_alu_responder.md
Name: base_alu_responder

Overview:
- Responder end of the operation/operand/base_select/result/done interface driven by the benchmark controller.
- Accepts one request at a time. Executes one of 9 ALU ops under a cost model that depends on the selected base (2, 10 or 12).
- Returns a registered result with a one-cycle done pulse.
- Keeps cumulative busy-cycle and completion counters so benchmark runs can be cross-checked against the controller's own timers.

Parameters:
- WIDTH, 32, operand/result width.
- FAST_CYCLES, 1, execute cycles when the op is native to the selected base.
- SLOW_CYCLES, 3, execute cycles otherwise. Must be >= FAST_CYCLES, 1..15.
- DIV_ZERO_VALUE, all-ones, result returned for divide by zero.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request strobe; sampled only when req_ready=1.
- req_ready  out  1  high in IDLE only (decoded from state register).
- operation  in  4  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR; 9-15 illegal.
- operand_a  in  WIDTH  first operand.
- operand_b  in  WIDTH  second operand / shift amount.
- base_select  in  2  0 base-2, 1 base-10, 2 base-12, 3 illegal.
- result  out  WIDTH  registered result; holds until next completion.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done for illegal op/base or divide by zero.
- busy_cycles  out  32  count of cycles spent in EXEC; saturates at all-ones.
- ops_completed  out  16  count of done pulses; wraps modulo 2^16.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, result=0, done=0, err=0, busy_cycles=0, ops_completed=0, internal latches=0. Counters clear only on reset.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - On req_valid=1, latch operation, operand_a, operand_b and base_select.
  - Load cnt = cost-1 and go to EXEC.
  - Inputs are ignored after acceptance, so the controller may change them freely.
- Cost:
  - FAST_CYCLES if (base 0 and op 0-2), (base 1 and op 3-5), or (base 2 and op 6-8). Otherwise SLOW_CYCLES.
  - Illegal op or base always costs FAST_CYCLES.
- EXEC:
  - busy_cycles increments each cycle (saturating).
  - If cnt!=0, cnt decrements. If cnt==0, compute from the latched values, register result/err, and go to DONE.
- DONE:
  - done=1 (and err if flagged) for exactly this cycle.
  - ops_completed++. Go to IDLE; req_ready returns the next cycle.
- Latency:
  - Request accepted on edge k gives done high in the cycle following edge k+cost+1.
  - Minimum request spacing is cost+2 cycles.
- Arithmetic:
  - ADD/SUB modulo 2^WIDTH.
  - MUL keeps the low WIDTH bits.
  - DIV is the unsigned quotient; b=0 gives DIV_ZERO_VALUE with err=1.
  - SHL/SHR are logical shifts by operand_b[4:0].
- Illegal op (9-15) or base 3: result=0, err=1, normal done.
- req_valid while req_ready=0 is ignored and not queued.
- Reset mid-EXEC aborts the operation: no done pulse, and the counters are cleared.

Decomposition:
- Package base_alu_pkg: op code constants, base code constants, FSM state encoding, and a cost function (op, base, FAST, SLOW).
- Sub-module base_alu_datapath: purely combinational result/err from (op, a, b, base validity).
- The FSM, counters and registers stay in the top.

Test Plan:
1. ADD a=0x1234 b=0x5678 base 0 -> result 0x68AC, err=0, done exactly 3 cycles after accept edge (cost 1), ops_completed=1, busy_cycles=1.
2. DIV a=100 b=10: base 1 -> 10 with cost 1; repeat with base 0 -> 10 with cost 3; busy_cycles total 4.
3. MUL 0xFF*0xAA base 2 -> 0x0000A956 with cost 3. SHR 144 by 4 base 2 -> 9 with cost 1. XOR 12^6 base 2 -> 10.
4. DIV a=5 b=0 base 1 -> result all-ones, err pulse with done. Op 9, or base 3 with ADD -> result 0, err=1, cost 1.
5. Second req_valid held during EXEC -> ignored. Only one done pulse; next request accepted only after req_ready rises.
6. Assert reset_n=0 mid-EXEC of a SLOW op -> no done pulse, all outputs 0 immediately; a fresh ADD after release completes normally.
